// File: rtl/sdpram_bist_ctrl.sv
// Built-in self test for a simple dual-port RAM: writes a pattern to every
// address, reads it back, counts mismatches and records the first failing address.
module sdpram_bist_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1,
  parameter int ERR_WIDTH  = 16
) (
  input  logic                  wr_clk,
  input  logic                  tb_wr_rst,
  input  logic                  start,
  input  logic [1:0]            mode,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_WIDTH-1:0]  err_cnt,
  output logic [ADDR_WIDTH-1:0] first_err_addr
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  state_t                state;
  logic [1:0]            mode_q;
  logic [1:0]            drain_cnt;
  logic                  vld_p      [RD_LATENCY];
  logic [ADDR_WIDTH-1:0] exp_addr_p [RD_LATENCY];
  logic [DATA_WIDTH-1:0] exp_data_p [RD_LATENCY];
  logic                  mismatch;

  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [1:0] m,
                                                    input logic [ADDR_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] p;
    int                    bit_sel;
    bit_sel = int'(32'(a) % DATA_WIDTH);
    p = '0;
    case (m)
      2'd0:    p = '1 - DATA_WIDTH'(a);
      2'd1:    p = DATA_WIDTH'(a);
      2'd2:    for (int i = 0; i < DATA_WIDTH; i++) p[i] = (i[0] == a[0]);
      default: for (int i = 0; i < DATA_WIDTH; i++) p[i] = (i == bit_sel);
    endcase
    return p;
  endfunction

  function automatic logic [ERR_WIDTH-1:0] sat_inc(input logic [ERR_WIDTH-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  assign mismatch = vld_p[RD_LATENCY-1] && (ram_rd_data != exp_data_p[RD_LATENCY-1]);
  assign pass     = done && (err_cnt == '0);

  always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
    if (tb_wr_rst) begin
      state          <= IDLE;
      mode_q         <= 2'd0;
      drain_cnt      <= 2'd0;
      ram_wr_en      <= 1'b0;
      ram_wr_addr    <= '0;
      ram_wr_data    <= '0;
      ram_rd_en      <= 1'b0;
      ram_rd_addr    <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state          <= WRITE;
            mode_q         <= mode;
            busy           <= 1'b1;
            done           <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            ram_wr_en      <= 1'b1;
            ram_wr_addr    <= '0;
            ram_wr_data    <= pattern(mode, '0);
          end
        end
        WRITE: begin
          if (ram_wr_addr == '1) begin
            state       <= READ;
            ram_wr_en   <= 1'b0;
            ram_wr_addr <= '0;
            ram_wr_data <= '0;
            ram_rd_en   <= 1'b1;
            ram_rd_addr <= '0;
          end else begin
            ram_wr_addr <= ram_wr_addr + 1'b1;
            ram_wr_data <= pattern(mode_q, ram_wr_addr + 1'b1);
          end
        end
        READ: begin
          if (ram_rd_addr == '1) begin
            state       <= DRAIN;
            ram_rd_en   <= 1'b0;
            ram_rd_addr <= '0;
            drain_cnt   <= 2'd0;
          end else begin
            ram_rd_addr <= ram_rd_addr + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt == 2'(RD_LATENCY - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase

      // The pipeline is empty in IDLE/DONE, so this never collides with the clear on start.
      if (mismatch) begin
        err_cnt <= sat_inc(err_cnt);
        if (err_cnt == '0) first_err_addr <= exp_addr_p[RD_LATENCY-1];
      end
    end
  end

  // Compare pipeline: valid bits reset so in-flight reads are dropped on abort.
  always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
    if (tb_wr_rst) begin
      for (int i = 0; i < RD_LATENCY; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[0] <= ram_rd_en;
      for (int i = 1; i < RD_LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge wr_clk) begin
    exp_addr_p[0] <= ram_rd_addr;
    exp_data_p[0] <= pattern(mode_q, ram_rd_addr);
    for (int i = 1; i < RD_LATENCY; i++) begin
      exp_addr_p[i] <= exp_addr_p[i-1];
      exp_data_p[i] <= exp_data_p[i-1];
    end
  end

endmodule

// File: doc/sdpram_bist_ctrl.md
SDPRAM_BIST_CTRL -- requirements
Module: sdpram_bist_ctrl

Interface
- REQ-001 ADDR_WIDTH, 10, RAM address width; DEPTH = 2**ADDR_WIDTH.
- REQ-002 DATA_WIDTH, 32, RAM data width, range 8..1152.
- REQ-003 RD_LATENCY, 1, RAM read latency in clocks, legal values 1 (no output reg) or 2 (output reg).
- REQ-004 ERR_WIDTH, 16, error counter width.
- REQ-005 wr_clk  in  1  single clock for both RAM ports and all logic.
- REQ-006 tb_wr_rst  in  1  reset, asynchronous, active-high.
- REQ-007 start  in  1  one-cycle request to run a test.
- REQ-008 mode  in  2  pattern select, sampled with start.
- REQ-009 ram_wr_en  out  1  RAM write enable.
- REQ-010 ram_wr_addr  out  ADDR_WIDTH  RAM write address.
- REQ-011 ram_wr_data  out  DATA_WIDTH  RAM write data.
- REQ-012 ram_rd_en  out  1  RAM read enable.
- REQ-013 ram_rd_addr  out  ADDR_WIDTH  RAM read address.
- REQ-014 ram_rd_data  in  DATA_WIDTH  RAM read data.
- REQ-015 busy  out  1  test in progress.
- REQ-016 done  out  1  test finished; held until next start.
- REQ-017 pass  out  1  done and zero errors.
- REQ-018 err_cnt  out  ERR_WIDTH  mismatch count.
- REQ-019 first_err_addr  out  ADDR_WIDTH  address of first mismatch.

Function
- REQ-020 FSM states IDLE, WRITE, READ, DRAIN, DONE; start sampled only in IDLE or DONE, ignored in WRITE/READ/DRAIN.
- REQ-021 IDLE/DONE + start -> WRITE; latch mode; clear err_cnt, first_err_addr, done; zero address counter.
- REQ-022 WRITE: ram_wr_en=1 every cycle, ram_wr_addr = 0..DEPTH-1 ascending, one per cycle; after address DEPTH-1 -> READ, counter wraps to 0.
- REQ-023 READ: ram_rd_en=1 every cycle, ram_rd_addr = 0..DEPTH-1 ascending; after DEPTH-1 -> DRAIN.
- REQ-024 DRAIN: exactly RD_LATENCY cycles, then -> DONE.
- REQ-025 Pattern P(a), a = address: mode 0 = all-ones minus a (mod 2**DATA_WIDTH); mode 1 = a zero-extended/truncated to DATA_WIDTH; mode 2 = 0x55.. repeated for even a, 0xAA.. for odd a; mode 3 = walking one, bit (a mod DATA_WIDTH) set.
- REQ-026 ram_wr_data = P(ram_wr_addr) whenever ram_wr_en=1; otherwise 0.
- REQ-027 Expected data and address pipelined RD_LATENCY stages alongside a valid bit set by ram_rd_en; compare ram_rd_data at the edge where the valid bit exits the pipeline.
- REQ-028 Mismatch: err_cnt += 1, saturating at all-ones; first_err_addr captured only when err_cnt was 0.
- REQ-029 done rises at edge 2*DEPTH+RD_LATENCY after the start-sampling edge; last compare occurs on the same edge.
- REQ-030 busy=1 in WRITE, READ, DRAIN only; pass = done AND err_cnt==0 (combinational).
- REQ-031 ram_wr_en and ram_rd_en never both 1 in the same cycle.
- REQ-032 start in DONE re-runs with a newly sampled mode; done deasserts on the next cycle.

Reset
- REQ-033 tb_wr_rst=1 forces IDLE immediately; all outputs 0: ram_wr_en, ram_rd_en, addresses, ram_wr_data, busy, done, pass, err_cnt, first_err_addr; pipeline valid bits cleared.
- REQ-034 Reset mid-test aborts without further RAM accesses; no compare occurs for in-flight reads.
- REQ-035 Release of reset takes effect at the next wr_clk edge; start on that edge is accepted.

Verification
- REQ-036 ADDR_WIDTH=4, DATA_WIDTH=32, RD_LATENCY=1, ideal RAM, mode 0 -> writes 0xFFFFFFFF..0xFFFFFFF0, done at edge 33, pass=1, err_cnt=0.
- REQ-037 Same, RD_LATENCY=2, RAM with output register, mode 3 -> done at edge 34, pass=1.
- REQ-038 RAM model with bit 0 stuck at 0, mode 2 -> 8 errors (odd-address 0xAA.. unaffected, even 0x55.. fail), err_cnt=8, first_err_addr=0, pass=0.
- REQ-039 ERR_WIDTH=2, stuck-at-0 bit 31, mode 0 -> err_cnt saturates at 3, first_err_addr=0.
- REQ-040 tb_wr_rst pulsed at WRITE address 5 -> all outputs 0 that cycle, state IDLE; following start completes with pass=1.
- REQ-041 start pulsed during READ -> ignored, done timing unchanged; start in DONE with mode 1 -> second run, pass=1.
